// File: rtl/mem_access.sv
// MEM stage of a MIPS-style pipeline: drives a simple req/ack data bus, extracts
// little-endian byte/halfword load data and forwards writeback fields to WB.
module mem_access #(
    parameter int RegAddrWidth = 5,
    parameter int RegDataWidth = 32,
    parameter int OpcodeWidth  = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [RegAddrWidth-1:0] target_MEM,
    input  logic [RegDataWidth-1:0] data_from_ALU_MEM,
    input  logic                    we_hi_MEM,
    input  logic                    we_lo_MEM,
    input  logic [RegDataWidth-1:0] hi_MEM,
    input  logic [RegDataWidth-1:0] lo_MEM,
    input  logic [RegDataWidth-1:0] rdata_2_MEM,
    input  logic                    WriteReg_MEM,
    input  logic                    MemOrAlu_MEM,
    input  logic                    WriteMem_MEM,
    input  logic                    ReadMem_MEM,
    input  logic [OpcodeWidth-1:0]  opcode_MEM,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [31:0]             mem_addr,
    output logic [3:0]              mem_be,
    output logic [31:0]             mem_wdata,
    input  logic [31:0]             mem_rdata,
    input  logic                    mem_ack,
    output logic                    stall_req,
    output logic                    addr_error,
    output logic [RegAddrWidth-1:0] target_WB,
    output logic [RegDataWidth-1:0] data_WB,
    output logic                    WriteReg_WB,
    output logic                    we_hi_WB,
    output logic                    we_lo_WB,
    output logic [RegDataWidth-1:0] hi_WB,
    output logic [RegDataWidth-1:0] lo_WB
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [OpcodeWidth-1:0] OP_LB  = OpcodeWidth'(6'h20);
    localparam logic [OpcodeWidth-1:0] OP_LH  = OpcodeWidth'(6'h21);
    localparam logic [OpcodeWidth-1:0] OP_LBU = OpcodeWidth'(6'h24);
    localparam logic [OpcodeWidth-1:0] OP_LHU = OpcodeWidth'(6'h25);
    localparam logic [OpcodeWidth-1:0] OP_SB  = OpcodeWidth'(6'h28);
    localparam logic [OpcodeWidth-1:0] OP_SH  = OpcodeWidth'(6'h29);

    logic [1:0]              state;
    logic [1:0]              state_next;
    logic [31:0]             load_data;
    logic [31:0]             addr;
    logic [31:0]             store_word;
    logic                    is_byte;
    logic                    is_half;
    logic                    is_word;
    logic                    access;
    logic                    misaligned;
    logic                    mem_op;
    logic [7:0]              byte_sel;
    logic [15:0]             half_sel;
    logic [RegDataWidth-1:0] load_result;

    assign addr       = data_from_ALU_MEM[31:0];
    assign store_word = rdata_2_MEM[31:0];

    // Access size comes from the opcode; unknown load/store opcodes are whole-word.
    assign is_byte    = (opcode_MEM == OP_LB) || (opcode_MEM == OP_LBU) || (opcode_MEM == OP_SB);
    assign is_half    = (opcode_MEM == OP_LH) || (opcode_MEM == OP_LHU) || (opcode_MEM == OP_SH);
    assign is_word    = !is_byte && !is_half;
    assign access     = ReadMem_MEM || WriteMem_MEM;
    assign misaligned = access && ((is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00)));
    assign mem_op     = access && !misaligned;

    assign mem_req    = !rst && (((state == IDLE) && mem_op) || (state == WAIT));
    assign stall_req  = mem_req;
    assign addr_error = !rst && (state == IDLE) && misaligned;

    assign mem_we     = WriteMem_MEM;
    assign mem_addr   = {addr[31:2], 2'b00};

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves a latch.
        mem_wdata = store_word;
        mem_be    = 4'b1111;
        if (WriteMem_MEM) begin
            if (opcode_MEM == OP_SB) begin
                mem_wdata = {4{store_word[7:0]}};
                mem_be    = 4'b0001 << addr[1:0];
            end else if (opcode_MEM == OP_SH) begin
                mem_wdata = {2{store_word[15:0]}};
                mem_be    = addr[1] ? 4'b1100 : 4'b0011;
            end
        end
    end

    // Lane k of the registered word holds the byte at addr[1:0]=k.
    assign byte_sel = load_data[{addr[1:0], 3'b000} +: 8];
    assign half_sel = load_data[{addr[1], 4'b0000} +: 16];

    always_comb begin
        load_result = RegDataWidth'(load_data);
        case (opcode_MEM)
            OP_LB:   load_result = {{(RegDataWidth-8){byte_sel[7]}}, byte_sel};
            OP_LBU:  load_result = {{(RegDataWidth-8){1'b0}}, byte_sel};
            OP_LH:   load_result = {{(RegDataWidth-16){half_sel[15]}}, half_sel};
            OP_LHU:  load_result = {{(RegDataWidth-16){1'b0}}, half_sel};
            default: load_result = RegDataWidth'(load_data);
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (mem_op) state_next = mem_ack ? DONE : WAIT;
            WAIT: if (mem_ack) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignment so every register samples pre-edge values.
        if (rst) begin
            state     <= IDLE;
            // NOTE: the load register is a single word, not a memory array, so it is cheap to reset and a post-reset read shows 0.
            load_data <= '0;
        end else begin
            state <= state_next;
            if (mem_req && mem_ack && ReadMem_MEM) begin
                load_data <= mem_rdata;
            end
        end
    end

    // Writeback forwarding; enables are suppressed while the access is still in flight.
    assign target_WB   = target_MEM;
    assign data_WB     = MemOrAlu_MEM ? load_result : data_from_ALU_MEM;
    assign WriteReg_WB = WriteReg_MEM && !rst && !stall_req && !addr_error;
    assign we_hi_WB    = we_hi_MEM && !rst && !stall_req;
    assign we_lo_WB    = we_lo_MEM && !rst && !stall_req;
    assign hi_WB       = hi_MEM;
    assign lo_WB       = lo_MEM;

endmodule
